// File: rtl/muldiv_seq_if.sv
// EX-stage <-> M-extension unit bundle: op request in, stall/done/result back.
// master = EX pipeline side, slave = muldiv_seq.
interface muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic            flush;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (output start, funct3, data1, data2, flush,
                    input  stall, done, result);
    modport slave  (input  start, funct3, data1, data2, flush,
                    output stall, done, result);
endinterface

// File: rtl/muldiv_seq.sv
// RV32M iterative multiply/divide: XLEN+1 cycles accept-to-done (1 for div-by-zero/overflow).
// Holds the pipeline via combinational stall while busy; flush aborts and releases stall at once.
module muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_seq_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              sa_q, sa_d, sb_q, sb_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              sgn1, sgn2, neg1, neg2, div_zero, div_ovf;
    logic [XLEN-1:0]   mag1, mag2, fast_res;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] step, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, fin;
    logic              stall, done;

    // Operand decode: which operands are signed, their magnitudes, and the div fast-path cases.
    always_comb begin
        sgn1     = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
        sgn2     = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
        neg1     = sgn1 & bus.data1[XLEN-1];
        neg2     = sgn2 & bus.data2[XLEN-1];
        mag1     = neg1 ? -bus.data1 : bus.data1;
        mag2     = neg2 ? -bus.data2 : bus.data2;
        div_zero = (bus.data2 == '0);
        div_ovf  = ~bus.funct3[0] & (bus.data1 == INT_MIN) & (bus.data2 == '1);
        if (bus.funct3[1])
            fast_res = div_zero ? bus.data1 : '0;
        else
            fast_res = div_zero ? '1 : INT_MIN;
    end

    // acc holds {product high, multiplier} for mul and {remainder, dividend/quotient} for div.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (!op_q[2])
            step = {mul_sum, acc_q[XLEN-1:1]};
        else if (div_diff[XLEN])
            step = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        else
            step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end

    always_comb begin
        prod_s = (sa_q ^ sb_q) ? -step : step;
        quo_s  = (sa_q ^ sb_q) ? -step[XLEN-1:0] : step[XLEN-1:0];
        rem_s  = sa_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:                 fin = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fin = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fin = quo_s;
            default:                fin = rem_s;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        result_d = result_q;
        stall    = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    stall = 1'b1;
                    op_d  = bus.funct3;
                    sa_d  = neg1;
                    sb_d  = neg2;
                    cnt_d = '0;
                    if (bus.funct3[2]) begin
                        opnd_d = mag2;
                        acc_d  = {{XLEN{1'b0}}, mag1};
                    end else begin
                        opnd_d = mag1;
                        acc_d  = {{XLEN{1'b0}}, mag2};
                    end
                    if (bus.funct3[2] && (div_zero || div_ovf)) begin
                        state_d  = S_DONE;
                        result_d = fast_res;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    stall = 1'b1;
                    acc_d = step;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN-1)) begin
                        state_d  = S_DONE;
                        result_d = fin;
                    end
                end
            end
            S_DONE: begin
                done    = ~bus.flush;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            result_q <= result_d;
        end
    end

    assign bus.stall  = stall;
    assign bus.done   = done;
    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed RV32M vectors plus an arithmetic reference model
// compared against stall/done/result every cycle.
module tb_muldiv_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    bit   armed = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    muldiv_seq_if #(.XLEN(32)) bus ();

    muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) armed <= 1'b1;
    end

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        int          lat;
    } vec_t;

    localparam int NV = 22;
    vec_t vt [NV] = '{
        '{3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33},
        '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33},
        '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33},
        '{3'd2, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33},
        '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33},
        '{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33},
        '{3'd5, 32'd100,      32'd7,        32'd14,       33},
        '{3'd7, 32'd100,      32'd7,        32'd2,        33},
        '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1},
        '{3'd6, 32'd5,        32'd0,        32'd5,        1},
        '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1},
        '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1},
        '{3'd0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33},
        '{3'd3, 32'h80000000, 32'h00000002, 32'h00000001, 33},
        '{3'd4, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 33},
        '{3'd6, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33},
        '{3'd5, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33},
        '{3'd7, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33},
        '{3'd4, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 1},
        '{3'd6, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 1},
        '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33},
        '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33}
    };

    // Reference: plain 64-bit arithmetic and the RV32M corner-case rules.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, p;
        longint unsigned ua, ub, up;
        logic   [31:0]   r;
        logic            ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
        case (f)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
            3'd3: begin up = ua * ub; r = up[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFFFFFF : ovf ? 32'h80000000 : 32'($signed(a) / $signed(b));
            3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: r = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)))
            return 1;
        return 33;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    // Per-cycle compare against the model's view of busy/done/held result.
    bit          m_busy = 1'b0;
    int          m_done_at = 0;
    logic [31:0] m_res = '0;
    logic [31:0] m_result = '0;

    initial begin
        logic exp_stall, exp_done;
        forever begin
            @(negedge clk);
            if (armed) begin
                exp_done  = m_busy && (cyc == m_done_at) && !bus.flush;
                exp_stall = (!m_busy && bus.start && !bus.flush) ||
                            (m_busy && (cyc < m_done_at) && !bus.flush);
                if (m_busy && cyc == m_done_at) m_result = m_res;
                chk("stall", 32'(bus.stall), 32'(exp_stall));
                chk("done", 32'(bus.done), 32'(exp_done));
                chk("result", bus.result, m_result);
            end
            if (rst) begin
                m_busy   = 1'b0;
                m_result = '0;
            end else if (m_busy && (bus.flush || cyc == m_done_at)) begin
                m_busy = 1'b0;
            end else if (!m_busy && bus.start && !bus.flush) begin
                m_busy    = 1'b1;
                m_done_at = cyc + model_lat(bus.funct3, bus.data1, bus.data2);
                m_res     = model(bus.funct3, bus.data1, bus.data2);
            end
        end
    end

    task automatic wait_done(output int dc);
        dc = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                dc = cyc;
                break;
            end
        end
        if (dc < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout at cycle %0d: got no done, expected done within 100 cycles", cyc);
        end
    endtask

    task automatic drive(input logic s, input logic fl, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        bus.start  = s;
        bus.flush  = fl;
        bus.funct3 = f;
        bus.data1  = a;
        bus.data2  = b;
    endtask

    initial begin
        int acc, dc;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.funct3 = '0;
        bus.data1  = '0;
        bus.data2  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_stall", 32'(bus.stall), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_result", bus.result, 32'd0);

        // Back-to-back vectors: each op accepted the cycle after the previous done.
        for (int i = 0; i < NV; i++) begin
            drive(1'b1, 1'b0, vt[i].f, vt[i].a, vt[i].b);
            acc = cyc;
            chk($sformatf("model_v%0d", i), model(vt[i].f, vt[i].a, vt[i].b), vt[i].r);
            wait_done(dc);
            if (dc >= 0) begin
                chk($sformatf("lat_v%0d", i), 32'(dc - acc), 32'(vt[i].lat));
                chk($sformatf("res_v%0d", i), bus.result, vt[i].r);
            end
        end
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);

        // Flush of a MUL ten cycles in, with the next op already presented.
        drive(1'b1, 1'b0, 3'd0, 32'd3, 32'd5);
        acc = cyc;
        repeat (9) drive(1'b1, 1'b0, 3'd0, 32'd3, 32'd5);
        drive(1'b1, 1'b1, 3'd5, 32'd9, 32'd3);
        chk("flush_cycle", 32'(cyc - acc), 32'd10);
        @(negedge clk);
        chk("flush_stall", 32'(bus.stall), 32'd0);
        chk("flush_done", 32'(bus.done), 32'd0);
        drive(1'b1, 1'b0, 3'd5, 32'd9, 32'd3);
        wait_done(dc);
        if (dc >= 0) begin
            chk("flush_next_lat", 32'(dc - acc), 32'd44);
            chk("flush_next_res", bus.result, 32'd3);
        end

        // start together with flush while idle must not be taken.
        drive(1'b1, 1'b1, 3'd0, 32'd2, 32'd2);
        @(negedge clk);
        chk("idle_flush_stall", 32'(bus.stall), 32'd0);
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        @(negedge clk);
        chk("idle_flush_done", 32'(bus.done), 32'd0);
        chk("idle_flush_result", bus.result, 32'd3);

        // Reset in the middle of a DIV with start held: re-accepted right after.
        drive(1'b1, 1'b0, 3'd4, 32'd100, 32'd7);
        acc = cyc;
        repeat (4) drive(1'b1, 1'b0, 3'd4, 32'd100, 32'd7);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_cycle", 32'(cyc - acc), 32'd6);
        @(negedge clk);
        chk("rst_stall", 32'(bus.stall), 32'd1);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", bus.result, 32'd0);
        wait_done(dc);
        if (dc >= 0) begin
            chk("rst_next_lat", 32'(dc - acc), 32'd39);
            chk("rst_next_res", bus.result, 32'd14);
        end
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog at cycle %0d: got no end of test, expected finish before 20000 cycles", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
